// File: rtl/fft_frame_ctrl_if.sv
// Handshake/control bundle between the FFT frame sequencer and its
// surroundings (sample source, dif_stage chain, frame consumer).
// o_timeout exists only when FFT_FRAME_CTRL_TIMEOUT_EN is defined.
interface fft_frame_ctrl_if #(
  parameter int FRAMES_W = 16
);
  logic                i_start;
  logic [FRAMES_W-1:0] i_num_frames;
  logic                i_abort;
  logic                i_vld;
  logic                o_ready;
  logic                o_fft_init;
  logic                o_fft_vld;
  logic                i_fft_vld;
  logic                i_clip_strb;
  logic                o_sof;
  logic                o_eof;
  logic                o_frame_clip;
  logic                o_busy;
  logic                o_done;
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  logic                o_timeout;
`endif

  // Controller side
  modport slave (
    input  i_start, i_num_frames, i_abort, i_vld, i_fft_vld, i_clip_strb,
    output o_ready, o_fft_init, o_fft_vld, o_sof, o_eof, o_frame_clip,
           o_busy, o_done
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    , output o_timeout
`endif
  );

  // Driver side (source, chain model, consumer)
  modport master (
    output i_start, i_num_frames, i_abort, i_vld, i_fft_vld, i_clip_strb,
    input  o_ready, o_fft_init, o_fft_vld, o_sof, o_eof, o_frame_clip,
           o_busy, o_done
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    , input o_timeout
`endif
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for a pipelined DIF FFT chain.
// Flushes the chain with an init pulse, admits a requested number of
// N = 2**TOTAL_STAGES sample frames, tracks frames leaving the last stage
// (sof/eof/clip markers) and pulses o_done on completion.
// Optional drain watchdog: define FFT_FRAME_CTRL_TIMEOUT_EN.
module fft_frame_ctrl #(
  parameter int TOTAL_STAGES = 8,
  parameter int FRAMES_W     = 16,
  parameter int INIT_CYCLES  = 4
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input logic             clk,
  input logic             i_rst_n,
  fft_frame_ctrl_if.slave bus
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0]       INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [TOTAL_STAGES-1:0] CNT_LAST  = '1;
  localparam logic [FRAMES_W-1:0]     FRAME_ONE = FRAMES_W'(1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    ret_idle_q, ret_idle_d;
  logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
  logic [FRAMES_W-1:0]     num_frames_q, num_frames_d;
  logic [TOTAL_STAGES-1:0] in_cnt_q, in_cnt_d;
  logic [TOTAL_STAGES-1:0] out_cnt_q, out_cnt_d;
  logic [FRAMES_W-1:0]     in_frames_q, in_frames_d;
  logic [FRAMES_W-1:0]     out_frames_q, out_frames_d;
  logic                    clip_q, clip_d;
  logic                    done_q, done_d;

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
`endif

  logic active;
  logic ready;
  logic fft_vld;
  logic out_vld;
  logic eof;
  logic in_wrap;
  logic out_last;

  // Handshake and frame markers are combinational so they line up with data
  always_comb begin
    active   = (state_q == RUN) || (state_q == DRAIN);
    ready    = (state_q == RUN);
    fft_vld  = bus.i_vld & ready;
    out_vld  = bus.i_fft_vld & active;
    eof      = out_vld & (out_cnt_q == CNT_LAST);
    in_wrap  = fft_vld & (in_cnt_q == CNT_LAST);
    out_last = eof & ((out_frames_q + FRAME_ONE) == num_frames_q);
  end

  assign bus.o_ready      = ready;
  assign bus.o_fft_vld    = fft_vld;
  assign bus.o_fft_init   = (state_q == INIT);
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_sof        = out_vld & (out_cnt_q == '0);
  assign bus.o_eof        = eof;
  assign bus.o_frame_clip = eof & (clip_q | bus.i_clip_strb);
  assign bus.o_done       = done_q;
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  assign bus.o_timeout    = timeout_q;
`endif

  // Next-state logic: sequencing, counters, clip sticky and completion
  always_comb begin
    state_d      = state_q;
    ret_idle_d   = ret_idle_q;
    init_cnt_d   = init_cnt_q;
    num_frames_d = num_frames_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    in_frames_d  = in_frames_q;
    out_frames_d = out_frames_q;
    clip_d       = clip_q;
    done_d       = 1'b0;
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    wdog_d       = '0;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!bus.i_abort && bus.i_start && (bus.i_num_frames != '0)) begin
          num_frames_d = bus.i_num_frames;
          ret_idle_d   = 1'b0;
          state_d      = INIT;
        end
      end

      INIT: begin
        if (bus.i_abort) ret_idle_d = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          if (ret_idle_d) begin
            state_d = IDLE;
          end else begin
            state_d      = RUN;
            in_cnt_d     = '0;
            out_cnt_d    = '0;
            in_frames_d  = '0;
            out_frames_d = '0;
            clip_d       = 1'b0;
          end
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      RUN, DRAIN: begin
        if (fft_vld) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_wrap) begin
            in_frames_d = in_frames_q + FRAME_ONE;
            if ((in_frames_q + FRAME_ONE) == num_frames_q) state_d = DRAIN;
          end
        end
        if (out_vld) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (eof) out_frames_d = out_frames_q + FRAME_ONE;
        end
        if (eof)                   clip_d = 1'b0;
        else if (bus.i_clip_strb)  clip_d = 1'b1;
`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
        if (state_q == DRAIN && !out_vld) begin
          if (wdog_q == WD_LAST) begin
            timeout_d  = 1'b1;
            state_d    = INIT;
            ret_idle_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
`endif
        if (out_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        if (bus.i_abort) begin
          done_d     = 1'b0;
          state_d    = INIT;
          ret_idle_d = 1'b1;
        end
      end

      default: state_d = INIT;
    endcase
  end

  // State register; reset parks in INIT so the chain is flushed after reset
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= INIT;
      ret_idle_q   <= 1'b1;
      init_cnt_q   <= '0;
      num_frames_q <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      in_frames_q  <= '0;
      out_frames_q <= '0;
      clip_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_idle_q   <= ret_idle_d;
      init_cnt_q   <= init_cnt_d;
      num_frames_q <= num_frames_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      in_frames_q  <= in_frames_d;
      out_frames_q <= out_frames_d;
      clip_q       <= clip_d;
      done_q       <= done_d;
    end
  end

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
  // Drain watchdog counter and its one-cycle timeout pulse
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
